// File: rtl/prog_priority_encoder_pipe.sv
// prog_priority_encoder_pipe
//   Two-stage pipelined programmable priority encoder. A WIDTH-bit request
//   vector is searched upward from an effective start pointer (0, in_ptr or
//   the internal round-robin pointer) with wrap-around. The winning index and
//   its one-hot are returned on a registered valid/ready output.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     request handshake
//   in_req                request bits, bit i = requester i
//   in_mode               0 LSB-first, 1 programmed pointer, 2 round-robin, 3 = 0
//   in_ptr                start pointer (mode 1) / round-robin load value
//   ptr_load              load rr_ptr from in_ptr, independent of in_valid
//   out_valid/out_ready   result handshake
//   out_found             at least one request bit was set
//   out_idx, out_onehot   winning index and its one-hot (zero when not found)
//   rr_ptr                current round-robin pointer
//
// A request handshaked at edge e sits in stage 1 after e and appears on the
// outputs after e+1 (i.e. presented after edge k, visible from edge k+2).
module prog_priority_encoder_pipe #(
    parameter int WIDTH = 64,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_req,
    input  logic [1:0]       in_mode,
    input  logic [IDX_W-1:0] in_ptr,
    input  logic             ptr_load,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_found,
    output logic [IDX_W-1:0] out_idx,
    output logic [WIDTH-1:0] out_onehot,
    output logic [IDX_W-1:0] rr_ptr
);

    localparam int NG = WIDTH / 8;

    // stage 1 state
    logic                  s1_v_q,   s1_v_d;
    logic [NG-1:0][2:0]    s1_sub_q, s1_sub_d;
    logic [NG-1:0]         s1_any_q, s1_any_d;
    logic [IDX_W-1:0]      s1_ptr_q, s1_ptr_d;
    logic                  s1_rr_q,  s1_rr_d;

    // stage 2 (output) state
    logic                  out_valid_q,  out_valid_d;
    logic                  out_found_q,  out_found_d;
    logic [IDX_W-1:0]      out_idx_q,    out_idx_d;
    logic [WIDTH-1:0]      out_onehot_q, out_onehot_d;
    logic                  out_rr_q,     out_rr_d;
    logic [IDX_W-1:0]      rr_ptr_q,     rr_ptr_d;

    logic                  s1_adv, s2_adv;
    logic [IDX_W-1:0]      eff_ptr;
    logic [WIDTH-1:0]      rot_req;
    logic                  g_found;
    logic [IDX_W-1:0]      rot_idx;
    logic [IDX_W-1:0]      win_idx;

    // ---------------- pipeline control ----------------
    always_comb begin
        s2_adv   = !out_valid_q || out_ready;
        s1_adv   = s2_adv || !s1_v_q;
        in_ready = rst_n && s1_adv;
    end

    // ---------------- stage 1: rotate + group encode ----------------
    always_comb begin
        case (in_mode)
            2'd1:    eff_ptr = in_ptr;
            2'd2:    eff_ptr = rr_ptr_q;
            default: eff_ptr = '0;
        endcase
    end

    // rotate right by eff_ptr so that the search always starts at bit 0
    always_comb begin
        rot_req = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rot_req[i] = in_req[(i + int'(eff_ptr)) % WIDTH];
        end
    end

    always_comb begin
        s1_sub_d = s1_sub_q;
        s1_any_d = s1_any_q;
        s1_ptr_d = s1_ptr_q;
        s1_rr_d  = s1_rr_q;
        s1_v_d   = s1_v_q;
        if (s1_adv) begin
            s1_v_d   = in_valid && in_ready;
            s1_ptr_d = eff_ptr;
            s1_rr_d  = (in_mode == 2'd2);
            for (int g = 0; g < NG; g++) begin
                s1_any_d[g] = |rot_req[g*8 +: 8];
                s1_sub_d[g] = 3'd0;
                // descending scan leaves the lowest set bit
                for (int b = 7; b >= 0; b--) begin
                    if (rot_req[g*8 + b]) s1_sub_d[g] = 3'(b);
                end
            end
        end
    end

    // ---------------- stage 2: group select + un-rotate ----------------
    always_comb begin
        g_found = 1'b0;
        rot_idx = '0;
        for (int g = 0; g < NG; g++) begin
            if (!g_found && s1_any_q[g]) begin
                g_found = 1'b1;
                rot_idx = IDX_W'(g * 8) + IDX_W'(s1_sub_q[g]);
            end
        end
        // WIDTH is a power of two, so natural wrap gives mod WIDTH
        win_idx = rot_idx + s1_ptr_q;
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_found_d  = out_found_q;
        out_idx_d    = out_idx_q;
        out_onehot_d = out_onehot_q;
        out_rr_d     = out_rr_q;
        if (s2_adv) begin
            out_valid_d  = s1_v_q;
            out_found_d  = s1_v_q && g_found;
            out_idx_d    = (s1_v_q && g_found) ? win_idx : '0;
            out_onehot_d = (s1_v_q && g_found) ? (WIDTH'(1) << win_idx) : '0;
            out_rr_d     = s1_rr_q;
        end
    end

    // ptr_load has priority over the handshake-driven advance
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (ptr_load)
            rr_ptr_d = in_ptr;
        else if (out_valid_q && out_ready && out_rr_q && out_found_q)
            rr_ptr_d = out_idx_q + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q       <= 1'b0;
            s1_sub_q     <= '0;
            s1_any_q     <= '0;
            s1_ptr_q     <= '0;
            s1_rr_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_found_q  <= 1'b0;
            out_idx_q    <= '0;
            out_onehot_q <= '0;
            out_rr_q     <= 1'b0;
            rr_ptr_q     <= '0;
        end else begin
            s1_v_q       <= s1_v_d;
            s1_sub_q     <= s1_sub_d;
            s1_any_q     <= s1_any_d;
            s1_ptr_q     <= s1_ptr_d;
            s1_rr_q      <= s1_rr_d;
            out_valid_q  <= out_valid_d;
            out_found_q  <= out_found_d;
            out_idx_q    <= out_idx_d;
            out_onehot_q <= out_onehot_d;
            out_rr_q     <= out_rr_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_found  = out_found_q;
    assign out_idx    = out_idx_q;
    assign out_onehot = out_onehot_q;
    assign rr_ptr     = rr_ptr_q;

endmodule

// File: tb/tb_prog_priority_encoder_pipe.sv
module tb_prog_priority_encoder_pipe;

    localparam int W  = 64;
    localparam int IW = 6;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_req;
    logic [1:0]    in_mode;
    logic [IW-1:0] in_ptr;
    logic          ptr_load;
    logic          out_valid;
    logic          out_ready;
    logic          out_found;
    logic [IW-1:0] out_idx;
    logic [W-1:0]  out_onehot;
    logic [IW-1:0] rr_ptr;

    int errors = 0;
    int checks = 0;

    prog_priority_encoder_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_req(in_req),
        .in_mode(in_mode), .in_ptr(in_ptr), .ptr_load(ptr_load),
        .out_valid(out_valid), .out_ready(out_ready), .out_found(out_found),
        .out_idx(out_idx), .out_onehot(out_onehot), .rr_ptr(rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present a request, wait (bounded) for in_ready, then handshake on the next edge
    task automatic send(input logic [W-1:0] req, input logic [1:0] mode, input logic [IW-1:0] ptr);
        int n;
        in_req = req; in_mode = mode; in_ptr = ptr; in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin step(); n++; end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL send_ready: in_ready=%0b required 1 within 20 cycles", in_ready); end
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (out_found !== 1'b0) begin errors++; $display("FAIL reset_out_found: got %0b want 0", out_found); end
        checks++; if (out_idx !== 6'd0) begin errors++; $display("FAIL reset_out_idx: got %0d want 0", out_idx); end
        checks++; if (out_onehot !== 64'd0) begin errors++; $display("FAIL reset_onehot: got %h want 0", out_onehot); end
        checks++; if (rr_ptr !== 6'd0) begin errors++; $display("FAIL reset_rr_ptr: got %0d want 0", rr_ptr); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %0b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %0b want 0", out_valid); end
    endtask

    task automatic test_lsb_first();
        out_ready = 1'b1;
        in_req = 64'h0000_0000_0001_0100; in_mode = 2'd0; in_ptr = 6'd33; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lsb_latency_early: out_valid=%0b want 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lsb_valid: got %0b want 1", out_valid); end
        checks++; if (out_found !== 1'b1) begin errors++; $display("FAIL lsb_found: got %0b want 1", out_found); end
        checks++; if (out_idx !== 6'd8) begin errors++; $display("FAIL lsb_idx: got %0d want 8", out_idx); end
        checks++; if (out_onehot !== 64'h100) begin errors++; $display("FAIL lsb_onehot: got %h want 100", out_onehot); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lsb_retired: out_valid=%0b want 0", out_valid); end
    endtask

    task automatic test_programmed_ptr();
        logic [W-1:0]  req;
        logic [IW-1:0] ptrs [4];
        logic [IW-1:0] exps [4];
        req = '0; req[3] = 1'b1; req[20] = 1'b1; req[45] = 1'b1;
        ptrs = '{6'd40, 6'd50, 6'd3, 6'd63};
        exps = '{6'd45, 6'd3,  6'd3, 6'd3};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(req, 2'd1, ptrs[i]);
            step();
            checks++; if (out_valid !== 1'b1 || out_idx !== exps[i]) begin errors++; $display("FAIL ptr_idx[%0d]: valid=%0b idx=%0d want valid=1 idx=%0d", i, out_valid, out_idx, exps[i]); end
            step();
        end
        checks++; if (rr_ptr !== 6'd0) begin errors++; $display("FAIL ptr_rr_unchanged: got %0d want 0", rr_ptr); end
    endtask

    task automatic test_round_robin();
        logic [W-1:0]  req;
        logic [IW-1:0] exp_idx [3];
        logic [IW-1:0] exp_rr  [3];
        req = '0; req[5] = 1'b1; req[9] = 1'b1;
        exp_idx = '{6'd5, 6'd9,  6'd5};
        exp_rr  = '{6'd6, 6'd10, 6'd6};
        rst_n = 1'b0; step(); rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(req, 2'd2, 6'd0);
            step();
            checks++; if (out_valid !== 1'b1 || out_idx !== exp_idx[i]) begin errors++; $display("FAIL rr_idx[%0d]: valid=%0b idx=%0d want valid=1 idx=%0d", i, out_valid, out_idx, exp_idx[i]); end
            step();
            checks++; if (rr_ptr !== exp_rr[i]) begin errors++; $display("FAIL rr_ptr[%0d]: got %0d want %0d", i, rr_ptr, exp_rr[i]); end
        end
        // the retire alone would set rr_ptr to 10; the coincident load must win
        send(req, 2'd2, 6'd0);
        step();
        ptr_load = 1'b1; in_ptr = 6'd9;
        step();
        ptr_load = 1'b0;
        checks++; if (rr_ptr !== 6'd9) begin errors++; $display("FAIL rr_load_wins: got %0d want 9", rr_ptr); end
    endtask

    task automatic test_empty();
        out_ready = 1'b1;
        ptr_load = 1'b1; in_ptr = 6'd7;
        step();
        ptr_load = 1'b0;
        checks++; if (rr_ptr !== 6'd7) begin errors++; $display("FAIL empty_load: got %0d want 7", rr_ptr); end
        send('0, 2'd2, 6'd0);
        step();
        checks++; if (out_valid !== 1'b1 || out_found !== 1'b0) begin errors++; $display("FAIL empty_found: valid=%0b found=%0b want 1/0", out_valid, out_found); end
        checks++; if (out_idx !== 6'd0 || out_onehot !== 64'd0) begin errors++; $display("FAIL empty_idx: idx=%0d onehot=%h want 0/0", out_idx, out_onehot); end
        step();
        checks++; if (rr_ptr !== 6'd7) begin errors++; $display("FAIL empty_rr_kept: got %0d want 7", rr_ptr); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_mode = 2'd0; in_valid = 1'b1;
        in_req = 64'h2;                            // A -> 1
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_a: got %0b want 1", in_ready); end
        step();
        in_req = 64'h2_0000;                       // B -> 17
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_b: got %0b want 1", in_ready); end
        step();
        in_req = 64'h100_0000_0000;                // C -> 40
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: in_ready=%0b want 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_idx !== 6'd1) begin errors++; $display("FAIL bp_head_a: valid=%0b idx=%0d want 1/1", out_valid, out_idx); end
        step();
        checks++; if (out_valid !== 1'b1 || out_idx !== 6'd1 || out_onehot !== 64'h2 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_hold: valid=%0b idx=%0d onehot=%h ready=%0b want 1/1/2/0", out_valid, out_idx, out_onehot, in_ready); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise: got %0b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_idx !== 6'd17) begin errors++; $display("FAIL bp_b: valid=%0b idx=%0d want 1/17", out_valid, out_idx); end
        step();
        checks++; if (out_valid !== 1'b1 || out_idx !== 6'd40) begin errors++; $display("FAIL bp_c: valid=%0b idx=%0d want 1/40", out_valid, out_idx); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: out_valid=%0b want 0", out_valid); end
        checks++; if (rr_ptr !== 6'd7) begin errors++; $display("FAIL bp_rr_kept: got %0d want 7", rr_ptr); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        ptr_load = 1'b1; in_ptr = 6'd13;
        step();
        ptr_load = 1'b0;
        out_ready = 1'b0;
        send(64'h8, 2'd0, 6'd0);
        send(64'h10, 2'd0, 6'd0);
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_full: ready=%0b valid=%0b want 0/1", in_ready, out_valid); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || rr_ptr !== 6'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset: valid=%0b rr=%0d ready=%0b want 0/0/1", out_valid, rr_ptr, in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale[%0d]: out_valid=%0b want 0", i, out_valid); end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_req = '0; in_mode = 2'd0;
        in_ptr = '0; ptr_load = 1'b0; out_ready = 1'b0;
        test_reset();
        test_lsb_first();
        test_programmed_ptr();
        test_round_robin();
        test_empty();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
